// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side bus arbiter: FSM state encoding,
// access size codes, grant identifiers and the default wait limit.
package cpu_bus_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_DATA  = 2'd2;

  // funct3-style size/sign codes carried on d_size and m_size
  localparam logic [2:0] SIZE_BYTE   = 3'b000;
  localparam logic [2:0] SIZE_HALF   = 3'b001;
  localparam logic [2:0] SIZE_WORD   = 3'b010;
  localparam logic [2:0] SIZE_DWORD  = 3'b011;
  localparam logic [2:0] SIZE_BYTEU  = 3'b100;
  localparam logic [2:0] SIZE_HALFU  = 3'b101;
  localparam logic [2:0] SIZE_WORDU  = 3'b110;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/bus_wait_timer.sv
// Counts cycles a granted transaction waits for m_ready and flags the
// cycle in which the count would reach the limit.
module bus_wait_timer
  import cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

  logic [3:0] count_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q <= 4'd0;
    end else if (clear_i) begin
      count_q <= 4'd0;
    end else if (inc_i) begin
      count_q <= count_q + 4'd1;
    end
  end

  // Expires on the wait cycle that would bring the count up to TIMEOUT,
  // so exactly TIMEOUT unanswered cycles are tolerated.
  assign expired_o = inc_i && (count_q == LAST_WAIT);

endmodule

// File: rtl/bus_arbiter.sv
// Serialises instruction-fetch and data requests onto a single memory port,
// round-robin on ties, with a bounded wait for the memory handshake.
module bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_done,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_size,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              m_valid,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [2:0]        m_size,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall_o,
  output logic              err
);

  state_t              state_q, state_d;
  grant_e              lastGrant_q, lastGrant_d;
  logic                mValid_q, mValid_d;
  logic                mWrite_q, mWrite_d;
  logic [ADDR_W-1:0]   mAddr_q, mAddr_d;
  logic [DATA_W-1:0]   mWdata_q, mWdata_d;
  logic [2:0]          mSize_q, mSize_d;
  logic [DATA_W-1:0]   fRdata_q, fRdata_d;
  logic [DATA_W-1:0]   dRdata_q, dRdata_d;
  logic                fDone_q, fDone_d;
  logic                dDone_q, dDone_d;
  logic                err_q, err_d;

  logic                fPending;
  logic                dPending;
  grant_e              grantSel;
  logic                timerClear;
  logic                timerInc;
  logic                timerExpired;

  // A request still high during its own done cycle is the old one being
  // released, so it only becomes eligible again one cycle later.
  assign fPending = f_req & ~fDone_q;
  assign dPending = d_req & ~dDone_q;

  always_comb begin
    grantSel = GRANT_FETCH;
    if (fPending && dPending) begin
      grantSel = (lastGrant_q == GRANT_FETCH) ? GRANT_DATA : GRANT_FETCH;
    end else if (dPending) begin
      grantSel = GRANT_DATA;
    end
  end

  bus_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .CLK       (CLK),
    .RESET     (RESET),
    .clear_i   (timerClear),
    .inc_i     (timerInc),
    .expired_o (timerExpired)
  );

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    mValid_d    = mValid_q;
    mWrite_d    = mWrite_q;
    mAddr_d     = mAddr_q;
    mWdata_d    = mWdata_q;
    mSize_d     = mSize_q;
    fRdata_d    = fRdata_q;
    dRdata_d    = dRdata_q;
    fDone_d     = 1'b0;
    dDone_d     = 1'b0;
    err_d       = 1'b0;
    timerClear  = 1'b0;
    timerInc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fPending || dPending) begin
          timerClear  = 1'b1;
          lastGrant_d = grantSel;
          mValid_d    = 1'b1;
          if (grantSel == GRANT_DATA) begin
            state_d  = ST_DATA;
            mWrite_d = d_write;
            mAddr_d  = d_addr;
            mWdata_d = d_wdata;
            mSize_d  = d_size;
          end else begin
            state_d  = ST_FETCH;
            mWrite_d = 1'b0;
            mAddr_d  = f_addr;
            mWdata_d = '0;
            mSize_d  = SIZE_DWORD;
          end
        end
      end

      ST_FETCH, ST_DATA: begin
        if (m_ready) begin
          mValid_d = 1'b0;
          state_d  = ST_IDLE;
          if (state_q == ST_FETCH) begin
            fRdata_d = m_rdata;
            fDone_d  = 1'b1;
          end else begin
            dRdata_d = mWrite_q ? '0 : m_rdata;
            dDone_d  = 1'b1;
          end
        end else begin
          timerInc = 1'b1;
          // Abort: complete the requester with an error and zero data.
          if (timerExpired) begin
            mValid_d = 1'b0;
            state_d  = ST_IDLE;
            err_d    = 1'b1;
            if (state_q == ST_FETCH) begin
              fRdata_d = '0;
              fDone_d  = 1'b1;
            end else begin
              dRdata_d = '0;
              dDone_d  = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d  = ST_IDLE;
        mValid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      lastGrant_q <= GRANT_FETCH;
      mValid_q    <= 1'b0;
      mWrite_q    <= 1'b0;
      mAddr_q     <= '0;
      mWdata_q    <= '0;
      mSize_q     <= 3'b000;
      fRdata_q    <= '0;
      dRdata_q    <= '0;
      fDone_q     <= 1'b0;
      dDone_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      mValid_q    <= mValid_d;
      mWrite_q    <= mWrite_d;
      mAddr_q     <= mAddr_d;
      mWdata_q    <= mWdata_d;
      mSize_q     <= mSize_d;
      fRdata_q    <= fRdata_d;
      dRdata_q    <= dRdata_d;
      fDone_q     <= fDone_d;
      dDone_q     <= dDone_d;
      err_q       <= err_d;
    end
  end

  assign m_valid = mValid_q;
  assign m_write = mWrite_q;
  assign m_addr  = mAddr_q;
  assign m_wdata = mWdata_q;
  assign m_size  = mSize_q;
  assign f_rdata = fRdata_q;
  assign d_rdata = dRdata_q;
  assign f_done  = fDone_q;
  assign d_done  = dDone_q;
  assign err     = err_q;

  assign stall_o = (f_req & ~fDone_q) | (d_req & ~dDone_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a memory responder checks issued
// transactions and a completion monitor checks done/rdata/err in order.
module tb_bus_arbiter;

  logic        CLK;
  logic        RESET;
  logic        f_req;
  logic [63:0] f_addr;
  logic [63:0] f_rdata;
  logic        f_done;
  logic        d_req;
  logic        d_write;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [2:0]  d_size;
  logic [63:0] d_rdata;
  logic        d_done;
  logic        m_valid;
  logic        m_write;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [2:0]  m_size;
  logic        m_ready;
  logic [63:0] m_rdata;
  logic        stall_o;
  logic        err;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    string       name;
    logic        isData;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    string       name;
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
    int          delay;
    logic [63:0] rdata;
    int          expCycles;
  } mem_t;

  exp_t expQ[$];
  mem_t memQ[$];

  bus_arbiter #(
    .ADDR_W  (64),
    .DATA_W  (64),
    .TIMEOUT (15)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_rdata (f_rdata),
    .f_done  (f_done),
    .d_req   (d_req),
    .d_write (d_write),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_size  (d_size),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .m_valid (m_valid),
    .m_write (m_write),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_size  (m_size),
    .m_ready (m_ready),
    .m_rdata (m_rdata),
    .stall_o (stall_o),
    .err     (err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic fReq, input logic [63:0] fAddr,
                               input logic dReq, input logic dWrite,
                               input logic [63:0] dAddr, input logic [63:0] dWdata,
                               input logic [2:0] dSize);
    f_req   = fReq;
    f_addr  = fAddr;
    d_req   = dReq;
    d_write = dWrite;
    d_addr  = dAddr;
    d_wdata = dWdata;
    d_size  = dSize;
  endtask

  task automatic expectTxn(input string name, input logic isData, input logic write,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [2:0] size, input int delay,
                           input logic [63:0] memRdata, input logic [63:0] expRdata,
                           input logic expErr, input int expCycles);
    mem_t m;
    exp_t e;
    m.name = name; m.write = write; m.addr = addr; m.wdata = wdata; m.size = size;
    m.delay = delay; m.rdata = memRdata; m.expCycles = expCycles;
    memQ.push_back(m);
    e.name = name; e.isData = isData; e.rdata = expRdata; e.err = expErr;
    expQ.push_back(e);
  endtask

  task automatic waitAnyDone(input string name, input int maxCycles, output int cycles);
    cycles = 0;
    do begin
      @(negedge CLK);
      cycles++;
    end while (!(f_done === 1'b1 || d_done === 1'b1) && cycles < maxCycles);
    if (!(f_done === 1'b1 || d_done === 1'b1)) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s_wait: no done within %0d cycles, required a done pulse",
               name, maxCycles);
    end
  endtask

  // Memory responder: checks each issued transaction and answers after its delay.
  initial begin : responder
    mem_t cur;
    int   validCycles;
    int   waited;
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge CLK);
      if (m_valid === 1'b1) begin
        if (memQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected_mvalid: got m_valid=1 addr 0x%0h, required idle", m_addr);
          for (int k = 0; k < 40 && m_valid === 1'b1; k++) @(negedge CLK);
        end else begin
          cur = memQ.pop_front();
          checkOutput({cur.name, "_addr"},  m_addr,  cur.addr);
          checkOutput({cur.name, "_write"}, {63'b0, m_write}, {63'b0, cur.write});
          checkOutput({cur.name, "_size"},  {61'b0, m_size},  {61'b0, cur.size});
          if (cur.write) checkOutput({cur.name, "_wdata"}, m_wdata, cur.wdata);
          validCycles = 1;
          waited      = 0;
          while (waited < cur.delay) begin
            @(negedge CLK);
            waited++;
            if (m_valid !== 1'b1) break;
            validCycles++;
            checkOutput({cur.name, "_stable_addr"}, m_addr, cur.addr);
            checkOutput({cur.name, "_stable_write"}, {63'b0, m_write}, {63'b0, cur.write});
            checkOutput({cur.name, "_stable_size"}, {61'b0, m_size}, {61'b0, cur.size});
            if (cur.write) checkOutput({cur.name, "_stable_wdata"}, m_wdata, cur.wdata);
          end
          if (m_valid === 1'b1 && waited == cur.delay) begin
            m_ready = 1'b1;
            m_rdata = cur.rdata;
            @(negedge CLK);
            m_ready = 1'b0;
            m_rdata = '0;
          end
          if (cur.expCycles >= 0)
            checkOutput({cur.name, "_valid_cycles"}, 64'(validCycles), 64'(cur.expCycles));
        end
      end
    end
  end

  // Completion monitor: pops the scoreboard on every done pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (f_done === 1'b1 || d_done === 1'b1) begin
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected_done: got f_done=%0b d_done=%0b, required none",
                   f_done, d_done);
        end else begin
          e = expQ.pop_front();
          checkOutput({e.name, "_single_done"}, {63'b0, f_done & d_done}, 64'd0);
          checkOutput({e.name, "_is_data"}, {63'b0, d_done}, {63'b0, e.isData});
          checkOutput({e.name, "_rdata"}, e.isData ? d_rdata : f_rdata, e.rdata);
          checkOutput({e.name, "_err"}, {63'b0, err}, {63'b0, e.err});
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int cyc;
    RESET = 1'b0;
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 3'b000);

    // Reset values
    repeat (2) @(negedge CLK);
    checkOutput("rst_m_valid", {63'b0, m_valid}, 64'd0);
    checkOutput("rst_m_addr", m_addr, 64'd0);
    checkOutput("rst_f_done", {63'b0, f_done}, 64'd0);
    checkOutput("rst_d_done", {63'b0, d_done}, 64'd0);
    checkOutput("rst_err", {63'b0, err}, 64'd0);
    checkOutput("rst_f_rdata", f_rdata, 64'd0);
    checkOutput("rst_d_rdata", d_rdata, 64'd0);
    checkOutput("rst_stall_idle", {63'b0, stall_o}, 64'd0);
    f_req = 1'b1;
    #1 checkOutput("rst_stall_follows_req", {63'b0, stall_o}, 64'd1);
    @(negedge CLK);
    f_req = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);

    // Single fetch with immediate m_ready: 2-cycle latency
    $display("[TB] single fetch");
    expectTxn("fetch1", 1'b0, 1'b0, 64'h1000, 64'h0, 3'b011, 0,
              64'h0000000000100093, 64'h100093, 1'b0, 1);
    applyStimulus(1'b1, 64'h1000, 1'b0, 1'b0, 64'h0, 64'h0, 3'b000);
    #1 checkOutput("fetch1_stall_pending", {63'b0, stall_o}, 64'd1);
    waitAnyDone("fetch1", 40, cyc);
    checkOutput("fetch1_latency", 64'(cyc), 64'd2);
    checkOutput("fetch1_stall_at_done", {63'b0, stall_o}, 64'd0);
    f_req = 1'b0;
    @(negedge CLK);

    // Simultaneous requests after reset: data first, then alternation
    $display("[TB] round-robin");
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    expectTxn("rr_d1", 1'b1, 1'b0, 64'h2000, 64'h0, 3'b010, 0, 64'h11, 64'h11, 1'b0, 1);
    expectTxn("rr_f1", 1'b0, 1'b0, 64'h3000, 64'h0, 3'b011, 0, 64'h22, 64'h22, 1'b0, 1);
    expectTxn("rr_d2", 1'b1, 1'b0, 64'h2000, 64'h0, 3'b010, 0, 64'h33, 64'h33, 1'b0, 1);
    expectTxn("rr_f2", 1'b0, 1'b0, 64'h3000, 64'h0, 3'b011, 0, 64'h44, 64'h44, 1'b0, 1);
    applyStimulus(1'b1, 64'h3000, 1'b1, 1'b0, 64'h2000, 64'h0, 3'b010);
    for (int i = 0; i < 4; i++) begin
      waitAnyDone("rr", 40, cyc);
      checkOutput("rr_gap", 64'(cyc), 64'd2);
      if (i == 2) d_req = 1'b0;
      if (i == 3) f_req = 1'b0;
    end
    @(negedge CLK);

    // Same requester held through done: re-served one cycle later
    $display("[TB] held fetch re-request");
    expectTxn("held_f1", 1'b0, 1'b0, 64'h8000, 64'h0, 3'b011, 0, 64'h81, 64'h81, 1'b0, 1);
    expectTxn("held_f2", 1'b0, 1'b0, 64'h8000, 64'h0, 3'b011, 0, 64'h82, 64'h82, 1'b0, 1);
    applyStimulus(1'b1, 64'h8000, 1'b0, 1'b0, 64'h0, 64'h0, 3'b000);
    waitAnyDone("held_f1", 40, cyc);
    checkOutput("held_f1_latency", 64'(cyc), 64'd2);
    waitAnyDone("held_f2", 40, cyc);
    checkOutput("held_f2_gap", 64'(cyc), 64'd3);
    f_req = 1'b0;
    @(negedge CLK);

    // Store with m_ready delayed by 3 cycles
    $display("[TB] delayed store");
    expectTxn("store", 1'b1, 1'b1, 64'h80000008, 64'hDEADBEEF, 3'b010, 3,
              64'hFFFF_0000_FFFF_0000, 64'h0, 1'b0, 4);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h80000008, 64'hDEADBEEF, 3'b010);
    waitAnyDone("store", 40, cyc);
    checkOutput("store_latency", 64'(cyc), 64'd5);
    d_req = 1'b0;
    @(negedge CLK);
    checkOutput("store_stall_after", {63'b0, stall_o}, 64'd0);

    // Memory never answers: abort after 15 wait cycles, then a normal load
    $display("[TB] timeout");
    expectTxn("timeout", 1'b0, 1'b0, 64'h4000, 64'h0, 3'b011, 99, 64'h0, 64'h0, 1'b1, 15);
    applyStimulus(1'b1, 64'h4000, 1'b0, 1'b0, 64'h0, 64'h0, 3'b000);
    waitAnyDone("timeout", 60, cyc);
    checkOutput("timeout_latency", 64'(cyc), 64'd16);
    f_req = 1'b0;
    @(negedge CLK);
    expectTxn("after_to", 1'b1, 1'b0, 64'h5000, 64'h0, 3'b011, 1, 64'h5555, 64'h5555, 1'b0, 2);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h5000, 64'h0, 3'b011);
    waitAnyDone("after_to", 40, cyc);
    checkOutput("after_to_latency", 64'(cyc), 64'd3);
    d_req = 1'b0;
    @(negedge CLK);

    // Reset while a data access waits: no done, re-served after release
    $display("[TB] reset mid-transaction");
    memQ.push_back('{name: "rst_mid", write: 1'b0, addr: 64'h6000, wdata: 64'h0,
                     size: 3'b011, delay: 99, rdata: 64'h0, expCycles: -1});
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h6000, 64'h0, 3'b011);
    repeat (3) @(negedge CLK);
    checkOutput("rst_mid_valid_before", {63'b0, m_valid}, 64'd1);
    RESET = 1'b0;
    #1 checkOutput("rst_mid_valid_drop", {63'b0, m_valid}, 64'd0);
    checkOutput("rst_mid_no_done", {63'b0, d_done}, 64'd0);
    @(negedge CLK);
    checkOutput("rst_mid_no_done_hold", {63'b0, d_done}, 64'd0);
    expectTxn("rst_reserve", 1'b1, 1'b0, 64'h6000, 64'h0, 3'b011, 0,
              64'h6666, 64'h6666, 1'b0, 1);
    RESET = 1'b1;
    waitAnyDone("rst_reserve", 40, cyc);
    checkOutput("rst_reserve_latency", 64'(cyc), 64'd2);
    d_req = 1'b0;
    @(negedge CLK);

    // Request dropped one cycle after grant still completes
    $display("[TB] dropped request");
    expectTxn("drop", 1'b1, 1'b0, 64'h7000, 64'h0, 3'b011, 2, 64'h7777, 64'h7777, 1'b0, 3);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h7000, 64'h0, 3'b011);
    @(negedge CLK);
    d_req = 1'b0;
    waitAnyDone("drop", 40, cyc);
    checkOutput("drop_latency", 64'(cyc), 64'd3);
    checkOutput("drop_stall_at_done", {63'b0, stall_o}, 64'd0);
    @(negedge CLK);
    checkOutput("drop_stall_after", {63'b0, stall_o}, 64'd0);
    checkOutput("drop_idle_after", {63'b0, m_valid}, 64'd0);

    repeat (3) @(negedge CLK);
    checkOutput("exp_queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("mem_queue_empty", 64'(memQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
